// File: rtl/if_id_flush_reg.sv
// IF/ID pipeline register: captures PC/instruction, holds on stall, and injects
// FLUSH_CYCLES NOP bubbles on a flush request. Optional bubble counter: IF_ID_FLUSH_COUNT_EN.
module if_id_flush_reg #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcIn,
  input  logic [31:0]     instrIn,
  input  logic            stall,
  input  logic            nopEnable,
  output logic [XLEN-1:0] pcOut,
  output logic [31:0]     instrOut,
  output logic            validOut,
  output logic            flushActive,
  output logic [31:0]     flushCount
);

  typedef enum logic [1:0] {RUN, FLUSH, STALL} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t          stateReg, stateNext;
  logic [2:0]      cntReg, cntNext;
  logic [XLEN-1:0] pcNext;
  logic [31:0]     instrNext;
  logic            validNext, flushNext;
  logic            loadBubble;

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    pcNext     = pcOut;
    instrNext  = instrOut;
    validNext  = validOut;
    flushNext  = flushActive;
    loadBubble = 1'b0;
    case (stateReg)
      FLUSH: begin
        // stall is ignored while bubbles drain; a new request restarts the count
        loadBubble = 1'b1;
        if (nopEnable) begin
          cntNext   = CNT_INIT;
          stateNext = (CNT_INIT != 3'd0) ? FLUSH : RUN;
        end else begin
          cntNext   = cntReg - 3'd1;
          stateNext = (cntReg == 3'd1) ? RUN : FLUSH;
        end
      end
      default: begin
        if (nopEnable) begin
          loadBubble = 1'b1;
          cntNext    = CNT_INIT;
          stateNext  = (CNT_INIT != 3'd0) ? FLUSH : RUN;
        end else if (stall) begin
          stateNext = STALL;
        end else begin
          pcNext    = pcIn;
          instrNext = instrIn;
          validNext = 1'b1;
          flushNext = 1'b0;
          stateNext = RUN;
        end
      end
    endcase
    // a bubble keeps the last PC so decode still sees a sensible address
    if (loadBubble) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
      flushNext = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= RUN;
      cntReg      <= 3'd0;
      pcOut       <= '0;
      instrOut    <= NOP_INSTR;
      validOut    <= 1'b0;
      flushActive <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      pcOut       <= pcNext;
      instrOut    <= instrNext;
      validOut    <= validNext;
      flushActive <= flushNext;
    end
  end

`ifdef IF_ID_FLUSH_COUNT_EN
  logic [31:0] flushCountReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           flushCountReg <= '0;
    else if (loadBubble) flushCountReg <= flushCountReg + 32'd1;
  end

  assign flushCount = flushCountReg;
`else
  assign flushCount = '0;
`endif

endmodule
